// File: rtl/definitions_pkg.sv
// Shared types for the display path: sign segment codes, 16-bit operand type,
// and the iterative BCD converter state encoding.
package definitions_pkg;

    typedef logic signed [15:0] int16_t;

    // Active-low segment pattern for the sign position: TEN lights only the middle bar.
    typedef enum logic [6:0] {
        TEN = 7'b0111111,
        OFF = 7'b1111111
    } sgmnt_e;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } bcd_state_e;

    localparam int BCD_DIGIT_W = 4;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adj
    import definitions_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    always_comb begin
        o_digit = i_digit;
        if (i_digit >= BCD_DIGIT_W'(5)) begin
            o_digit = i_digit + BCD_DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/signed_bcd_conv.sv
// Sequential two's-complement to sign + packed BCD converter with leading-zero blanking,
// one magnitude bit per cycle over valid/ready handshakes on both sides.
module signed_bcd_conv
    import definitions_pkg::*;
#(
    parameter int DW   = 16,
    parameter int NDIG = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DW-1:0]               i_data,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic [BCD_DIGIT_W*NDIG-1:0] o_digits,
    output logic [NDIG-1:0]             o_blank,
    output sgmnt_e                      o_sign,
    output logic                        o_valid,
    input  logic                        i_ready
);

    localparam int CNT_W = $clog2(DW);
    localparam int BCD_W = BCD_DIGIT_W * NDIG;

    bcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fin_q, fin_d;
    logic             sign_q, sign_d;
    logic [DW-1:0]    mag_q, mag_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [BCD_W-1:0] dig_q, dig_d;
    sgmnt_e           osign_q, osign_d;

    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W+DW-1:0] shifted;

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (bcd_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign shifted = {bcd_adj, mag_q} << 1;

    // fin_q adds one CONV cycle after the last shift so the result register
    // loads from the fully shifted BCD value on DONE entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fin_d   = fin_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        dig_d   = dig_q;
        osign_d = osign_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    sign_d  = i_data[DW-1];
                    mag_d   = i_data[DW-1] ? (~i_data + DW'(1)) : i_data;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(DW - 1);
                    fin_d   = 1'b0;
                    state_d = CONV;
                end
            end
            CONV: begin
                if (fin_q) begin
                    dig_d   = bcd_q;
                    osign_d = sign_q ? TEN : OFF;
                    state_d = DONE;
                end else begin
                    bcd_d = shifted[BCD_W+DW-1:DW];
                    mag_d = shifted[DW-1:0];
                    if (cnt_q == '0) begin
                        fin_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            bcd_q   <= '0;
            dig_q   <= '0;
            osign_q <= OFF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            dig_q   <= dig_d;
            osign_q <= osign_d;
        end
    end

    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        o_blank  = '0;
        for (int unsigned i = NDIG - 1; i > 0; i--) begin
            all_zero   = all_zero & (dig_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            o_blank[i] = all_zero;
        end
    end

    assign o_ready  = (state_q == IDLE);
    assign o_valid  = (state_q == DONE);
    assign o_digits = dig_q;
    assign o_sign   = osign_q;

endmodule

// File: tb/tb_signed_bcd_conv.sv
// Self-checking bench for signed_bcd_conv (DW=16, NDIG=5) with an expected-result queue.
module tb_signed_bcd_conv;
    import definitions_pkg::*;

    typedef struct {
        logic [19:0] dig;
        logic [4:0]  blk;
        sgmnt_e      sgn;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic [19:0] o_digits;
    logic [4:0]  o_blank;
    sgmnt_e      o_sign;
    logic        o_valid;
    logic        i_ready;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    signed_bcd_conv #(.DW(16), .NDIG(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .o_digits (o_digits),
        .o_blank  (o_blank),
        .o_sign   (o_sign),
        .o_valid  (o_valid),
        .i_ready  (i_ready)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] d);
        exp_t e;
        int   v, m;
        bit   z;
        v = int'($signed(d));
        m = (v < 0) ? -v : v;
        for (int i = 0; i < 5; i++) begin
            e.dig[i*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
        z = 1'b1;
        e.blk = '0;
        for (int i = 4; i >= 1; i--) begin
            z = z && (e.dig[i*4 +: 4] == 4'd0);
            e.blk[i] = z;
        end
        e.sgn = (v < 0) ? TEN : OFF;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand; the expectation is queued at the accepting edge.
    task automatic send(input logic [15:0] d);
        int n = 0;
        while (!o_ready && n < 100) begin
            tick();
            n++;
        end
        i_data  = d;
        i_valid = 1'b1;
        @(posedge clk);
        sb.push_back(model(d));
        #1;
        i_valid = 1'b0;
        i_data  = 16'($urandom);
    endtask

    task automatic get_result(output int lat, output bit timed_out);
        lat = 0;
        while (!o_valid && lat < 100) begin
            tick();
            lat++;
        end
        timed_out = !o_valid;
    endtask

    task automatic test_reset_init();
        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_data = '0;
        tick(); tick();
        rst_n = 1'b1;
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_digits !== 20'h0 ||
            o_sign !== OFF || o_blank !== 5'b11110) begin
            errors++;
            $display("FAIL reset_init: ready=%b valid=%b dig=%h sign=%h blank=%b, want 1 0 00000 %h 11110",
                     o_ready, o_valid, o_digits, o_sign, o_blank, OFF);
        end
    endtask

    task automatic test_values();
        logic [15:0] tbl [8] = '{16'd1234, 16'hFFFF, 16'h8000, 16'h7FFF,
                                 16'd0, 16'd9, 16'hFFF6, 16'd10000};
        exp_t e;
        int   lat;
        bit   to;
        i_ready = 1'b1;
        foreach (tbl[k]) begin
            send(tbl[k]);
            get_result(lat, to);
            e = sb.pop_front();
            checks++;
            if (to || lat != 17) begin
                errors++;
                $display("FAIL latency[%h]: got %0d timeout=%b, want 17", tbl[k], lat, to);
            end
            checks++;
            if (o_digits !== e.dig || o_blank !== e.blk || o_sign !== e.sgn) begin
                errors++;
                $display("FAIL value[%h]: dig=%h blank=%b sign=%h, want %h %b %h",
                         tbl[k], o_digits, o_blank, o_sign, e.dig, e.blk, e.sgn);
            end
            tick();
            checks++;
            if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
                errors++;
                $display("FAIL release[%h]: valid=%b ready=%b, want 0 1", tbl[k], o_valid, o_ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        send(16'd1234);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_digits !== 20'h0 || o_sign !== OFF) begin
            errors++;
            $display("FAIL reset_mid: ready=%b valid=%b dig=%h sign=%h, want 1 0 00000 %h",
                     o_ready, o_valid, o_digits, o_sign, OFF);
        end
        repeat (25) begin
            tick();
            if (o_valid) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL reset_discard: valid seen %0d cycles, want 0", n);
        end
    endtask

    task automatic test_backpressure();
        exp_t e, e2;
        int   lat;
        bit   to;
        int   bad = 0;
        i_ready = 1'b0;
        send(16'hFB2E);
        get_result(lat, to);
        e = sb.pop_front();
        checks++;
        if (to) begin
            errors++;
            $display("FAIL bp_timeout: o_valid=%b, want 1", o_valid);
        end
        repeat (10) begin
            i_data  = 16'($urandom);
            i_valid = ~i_valid;
            tick();
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_digits !== e.dig ||
                o_blank !== e.blk || o_sign !== e.sgn) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d unstable cycles, last dig=%h sign=%h valid=%b ready=%b, want %h %h 1 0",
                     bad, o_digits, o_sign, o_valid, o_ready, e.dig, e.sgn);
        end
        i_data  = 16'd4321;
        i_valid = 1'b1;
        i_ready = 1'b1;
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: valid=%b ready=%b, want 0 1", o_valid, o_ready);
        end
        @(posedge clk);
        sb.push_back(model(16'd4321));
        #1;
        i_valid = 1'b0;
        i_data  = 16'hFFFF;
        get_result(lat, to);
        e2 = sb.pop_front();
        checks++;
        if (to || lat != 17 || o_digits !== e2.dig || o_sign !== e2.sgn || o_blank !== e2.blk) begin
            errors++;
            $display("FAIL bp_second: lat=%0d dig=%h blank=%b sign=%h, want 17 %h %b %h",
                     lat, o_digits, o_blank, o_sign, e2.dig, e2.blk, e2.sgn);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        bit   to;
        logic [15:0] d;
        i_ready = 1'b1;
        repeat (12) begin
            d = 16'($urandom);
            send(d);
            get_result(lat, to);
            e = sb.pop_front();
            checks++;
            if (to || o_digits !== e.dig || o_blank !== e.blk || o_sign !== e.sgn) begin
                errors++;
                $display("FAIL b2b[%h]: dig=%h blank=%b sign=%h timeout=%b, want %h %b %h",
                         d, o_digits, o_blank, o_sign, to, e.dig, e.blk, e.sgn);
            end
        end
        tick();
    endtask

    initial begin
        test_reset_init();
        test_values();
        test_reset_mid();
        test_backpressure();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
